// File: rtl/adc733_pkg.sv
// Purpose : shared constants, FSM encoding and word helpers for the adc733 receiver.
// Latency : n/a (declarations only).
// Backpres: n/a.
package adc733_pkg;

    localparam int WORD_W        = 16;
    localparam int CTRL_FLAG_BIT = 15;
    localparam int BIT_CNT_W     = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } rx_state_e;

    // Control readback words carry a 1 in the top bit; samples carry a 0.
    function automatic logic is_ctrl(input logic [WORD_W-1:0] w);
        return w[CTRL_FLAG_BIT];
    endfunction

endpackage

// File: rtl/adc733_rx_if.sv
// Purpose : system-side bundle of the adc733 receiver (sample FIFO read port,
//           control readback, status pulses, channel sync and overflow clear).
// Latency : n/a (wiring only).
// Backpres: consumer pops with rd_en; no backpressure toward the converter.
// Ports   : master = system side (drives sync/rd_en/ovf_clr),
//           slave  = receiver side (drives read data, flags and pulses).
interface adc733_rx_if
    import adc733_pkg::*;
#(
    parameter int CH_W = 3
);
    logic              sync;
    logic              rd_en;
    logic              ovf_clr;
    logic [WORD_W-1:0] rd_data;
    logic [CH_W-1:0]   rd_channel;
    logic              rd_valid;
    logic              empty;
    logic [WORD_W-1:0] ctrl_word;
    logic              ctrl_valid;
    logic              frame_err;
    logic              overflow;

    modport master (
        output sync, rd_en, ovf_clr,
        input  rd_data, rd_channel, rd_valid, empty,
        input  ctrl_word, ctrl_valid, frame_err, overflow
    );

    modport slave (
        input  sync, rd_en, ovf_clr,
        output rd_data, rd_channel, rd_valid, empty,
        output ctrl_word, ctrl_valid, frame_err, overflow
    );
endinterface

// File: rtl/adc733_rx_fifo.sv
// Purpose : single-clock FIFO with registered read data and full/empty flags.
// Latency : write visible (empty low) the cycle after wr_en; rd_data one cycle after rd_en.
// Backpres: writes while full are ignored unless a pop happens in the same cycle.
// Ports   : clk/rst_l, wr_en/wr_data, rd_en -> rd_data/rd_valid, empty, full.
module adc733_rx_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             do_pop, do_push;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_pop  = rd_en && !empty;
    // A pop in the same cycle frees the slot, so a write on full still lands.
    assign do_push = wr_en && (!full || do_pop);

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        if (do_push) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (do_pop) begin
            rptr_d     = rptr_q + 1'b1;
            rd_data_d  = mem_q[rptr_q[AW-1:0]];
            rd_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q[AW-1:0]] <= wr_data;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: rtl/adc733_rx.sv
// Purpose : adc733 SDO deserializer; splits control readback from samples, tags
//           samples with a channel index and buffers them in a FIFO.
// Latency : LSB SCLK falling edge -> ctrl_valid / FIFO non-empty in 3 clk.
// Backpres: none toward the converter; samples arriving on a full FIFO are
//           dropped and flagged in the sticky overflow bit.
// Ports   : clk, rst_l, SCLK/SDOFS/SDO (async serial pins), bus (slave modport).
module adc733_rx
    import adc733_pkg::*;
#(
    parameter int NUM_CH     = 6,
    parameter int FIFO_DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst_l,
    input  logic         SCLK,
    input  logic         SDOFS,
    input  logic         SDO,
    adc733_rx_if.slave   bus
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    // Serial pin synchronizers; [1] is the stable stage.
    logic [1:0] sclk_sync_q, sdofs_sync_q, sdo_sync_q;
    logic       sclk_prev_q;
    logic       strobe, sdo_bit, fs_bit;

    rx_state_e             state_q, state_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0]     shift_q, shift_d;
    logic [WORD_W-1:0]     word_in;
    logic                  word_done;
    logic [CH_W-1:0]       chan_cnt_q, chan_cnt_d;
    logic [WORD_W-1:0]     ctrl_word_q, ctrl_word_d;
    logic                  ctrl_valid_q, ctrl_valid_d;
    logic                  frame_err_q, frame_err_d;
    logic                  overflow_q, overflow_d;

    logic                     sample_push;
    logic                     fifo_empty, fifo_full, fifo_pop, fifo_drop;
    logic [CH_W+WORD_W-1:0]   fifo_rd_data;

    // Data and frame sync come from the same stage as the edge, so the bit
    // seen at the strobe is the one that was stable across SCLK falling.
    assign strobe  = sclk_prev_q & ~sclk_sync_q[1];
    assign sdo_bit = sdo_sync_q[1];
    assign fs_bit  = sdofs_sync_q[1];
    assign word_in = {shift_q[WORD_W-2:0], sdo_bit};

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            sclk_sync_q  <= '0;
            sdofs_sync_q <= '0;
            sdo_sync_q   <= '0;
            sclk_prev_q  <= 1'b0;
        end else begin
            sclk_sync_q  <= {sclk_sync_q[0], SCLK};
            sdofs_sync_q <= {sdofs_sync_q[0], SDOFS};
            sdo_sync_q   <= {sdo_sync_q[0], SDO};
            sclk_prev_q  <= sclk_sync_q[1];
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        word_done   = 1'b0;
        if (strobe) begin
            case (state_q)
                IDLE: begin
                    if (fs_bit) begin
                        shift_d   = {{(WORD_W-1){1'b0}}, sdo_bit};
                        bit_cnt_d = BIT_CNT_W'(1);
                        state_d   = SHIFT;
                    end
                end
                SHIFT: begin
                    if (fs_bit) begin
                        // Frame restarted early: drop the partial word and
                        // treat this bit as the MSB of the new one.
                        frame_err_d = 1'b1;
                        shift_d     = {{(WORD_W-1){1'b0}}, sdo_bit};
                        bit_cnt_d   = BIT_CNT_W'(1);
                    end else if (bit_cnt_q == BIT_CNT_W'(WORD_W-1)) begin
                        word_done = 1'b1;
                        shift_d   = word_in;
                        bit_cnt_d = '0;
                        state_d   = IDLE;
                    end else begin
                        shift_d   = word_in;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign sample_push = word_done && !is_ctrl(word_in);
    assign fifo_pop    = bus.rd_en && !fifo_empty;
    assign fifo_drop   = sample_push && fifo_full && !fifo_pop;

    always_comb begin
        chan_cnt_d   = chan_cnt_q;
        ctrl_word_d  = ctrl_word_q;
        ctrl_valid_d = 1'b0;
        overflow_d   = overflow_q;
        if (word_done && is_ctrl(word_in)) begin
            ctrl_word_d  = word_in;
            ctrl_valid_d = 1'b1;
        end
        // Tag advances on every completed sample, stored or dropped.
        if (sample_push) begin
            chan_cnt_d = (chan_cnt_q == CH_W'(NUM_CH-1)) ? '0 : chan_cnt_q + 1'b1;
        end
        // A coincident sample already took the old tag via the FIFO write.
        if (bus.sync) begin
            chan_cnt_d = '0;
        end
        if (bus.ovf_clr) begin
            overflow_d = 1'b0;
        end
        // A drop in the same cycle as a clear keeps the flag set.
        if (fifo_drop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            chan_cnt_q   <= '0;
            ctrl_word_q  <= '0;
            ctrl_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            chan_cnt_q   <= chan_cnt_d;
            ctrl_word_q  <= ctrl_word_d;
            ctrl_valid_q <= ctrl_valid_d;
            frame_err_q  <= frame_err_d;
            overflow_q   <= overflow_d;
        end
    end

    adc733_rx_fifo #(
        .WIDTH (CH_W + WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_l    (rst_l),
        .wr_en    (sample_push),
        .wr_data  ({chan_cnt_q, word_in}),
        .rd_en    (bus.rd_en),
        .rd_data  (fifo_rd_data),
        .rd_valid (bus.rd_valid),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    assign bus.rd_data    = fifo_rd_data[WORD_W-1:0];
    assign bus.rd_channel = fifo_rd_data[WORD_W +: CH_W];
    assign bus.empty      = fifo_empty;
    assign bus.ctrl_word  = ctrl_word_q;
    assign bus.ctrl_valid = ctrl_valid_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_adc733_rx.sv
// Purpose : randomized + directed bench for adc733_rx with a queue-based reference
//           model and an independent output monitor.
// Latency : n/a.
// Backpres: n/a.
module tb_adc733_rx;
    import adc733_pkg::*;

    localparam int NUM_CH = 6;
    localparam int DEPTH  = 16;
    localparam int CH_W   = 3;

    logic clk, rst_l, SCLK, SDOFS, SDO;

    adc733_rx_if #(.CH_W(CH_W)) bus();

    adc733_rx #(.NUM_CH(NUM_CH), .FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_l (rst_l),
        .SCLK  (SCLK),
        .SDOFS (SDOFS),
        .SDO   (SDO),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: stored samples, expected outputs, channel and overflow state.
    logic [18:0] mfifo[$];
    logic [18:0] exp_rd_q[$];
    logic [15:0] exp_ctrl_q[$];
    int          m_ch = 0;
    logic        m_ovf = 1'b0;
    int          exp_ferr = 0;
    int          seen_ferr = 0;
    logic [18:0] mon_item;
    logic [15:0] mon_ctrl;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Monitor: compares every DUT output event against the scoreboard queues.
    always @(negedge clk) begin
        if (rst_l === 1'b1) begin
            if (bus.rd_valid === 1'b1) begin
                if (exp_rd_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL rd_unexpected: actual ch=%0d data=0x%0h required=no pop",
                             bus.rd_channel, bus.rd_data);
                end else begin
                    mon_item = exp_rd_q.pop_front();
                    check("rd_word", {13'd0, bus.rd_channel, bus.rd_data}, {13'd0, mon_item});
                end
            end
            if (bus.ctrl_valid === 1'b1) begin
                if (exp_ctrl_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL ctrl_unexpected: actual=0x%0h required=no ctrl_valid", bus.ctrl_word);
                end else begin
                    mon_ctrl = exp_ctrl_q.pop_front();
                    check("ctrl_word", {16'd0, bus.ctrl_word}, {16'd0, mon_ctrl});
                end
            end
            if (bus.frame_err === 1'b1) begin
                seen_ferr++;
            end
        end
    end

    // Model: a finished serial word.
    task automatic model_word(input logic [15:0] w);
        logic [2:0] tag;
        if (w[15]) begin
            exp_ctrl_q.push_back(w);
        end else begin
            tag = 3'(m_ch);
            if (mfifo.size() < DEPTH) mfifo.push_back({tag, w});
            else m_ovf = 1'b1;
            m_ch = (m_ch + 1) % NUM_CH;
        end
    endtask

    task automatic model_pop();
        if (mfifo.size() > 0) exp_rd_q.push_back(mfifo.pop_front());
    endtask

    // Shift bits w[hi]..w[lo]; SDOFS high on the first one if fs. Returns at the
    // last SCLK falling edge, 2 time units after a clk falling edge.
    task automatic send_bits(input logic [15:0] w, input int hi, input int lo, input bit fs);
        @(negedge clk);
        #2;
        for (int i = hi; i >= lo; i--) begin
            SCLK  = 1'b1;
            SDO   = w[i];
            SDOFS = fs && (i == hi);
            #30;
            SCLK  = 1'b0;
            if (i != lo) #30;
        end
        SDOFS = 1'b0;
    endtask

    task automatic settle_check(input string tag);
        repeat (4) @(posedge clk);
        #1;
        check({tag, "_empty"}, {31'd0, bus.empty}, {31'd0, (mfifo.size() == 0)});
        check({tag, "_ovf"}, {31'd0, bus.overflow}, {31'd0, m_ovf});
        repeat (2) @(negedge clk);
    endtask

    task automatic send_word(input logic [15:0] w, input string tag);
        send_bits(w, 15, 0, 1'b1);
        model_word(w);
        settle_check(tag);
    endtask

    // kind 0: sync, 1: ovf_clr, 2: rd_en -- asserted on the completion cycle.
    task automatic send_coincident(input logic [15:0] w, input int kind, input string tag);
        send_bits(w, 15, 0, 1'b1);
        repeat (2) @(negedge clk);
        case (kind)
            0: begin bus.sync = 1'b1; model_word(w); m_ch = 0; end
            1: begin bus.ovf_clr = 1'b1; m_ovf = 1'b0; model_word(w); end
            default: begin bus.rd_en = 1'b1; model_pop(); model_word(w); end
        endcase
        @(negedge clk);
        bus.sync = 1'b0;
        bus.ovf_clr = 1'b0;
        bus.rd_en = 1'b0;
        settle_check(tag);
    endtask

    task automatic do_pop();
        @(negedge clk);
        bus.rd_en = 1'b1;
        model_pop();
        @(negedge clk);
        bus.rd_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_sync();
        @(negedge clk);
        bus.sync = 1'b1;
        m_ch = 0;
        @(negedge clk);
        bus.sync = 1'b0;
    endtask

    task automatic do_clr();
        @(negedge clk);
        bus.ovf_clr = 1'b1;
        m_ovf = 1'b0;
        @(negedge clk);
        bus.ovf_clr = 1'b0;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] w;
        int r;
        rst_l = 1'b0;
        SCLK = 1'b0;
        SDOFS = 1'b0;
        SDO = 1'b0;
        bus.sync = 1'b0;
        bus.rd_en = 1'b0;
        bus.ovf_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_empty", {31'd0, bus.empty}, 32'd1);
        check("rst_ovf", {31'd0, bus.overflow}, 32'd0);
        check("rst_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
        check("rst_ctrl_valid", {31'd0, bus.ctrl_valid}, 32'd0);
        check("rst_frame_err", {31'd0, bus.frame_err}, 32'd0);
        check("rst_ctrl_word", {16'd0, bus.ctrl_word}, 32'd0);
        rst_l = 1'b1;
        repeat (3) @(negedge clk);

        // Data word, then control word.
        send_word(16'h1234, "data1");
        do_pop();
        send_word(16'h8901, "ctrl1");

        // Channel tag wrap, then sync mid-sequence.
        do_sync();
        for (int i = 1; i <= 7; i++) send_word(16'(i), "tagwrap");
        while (mfifo.size() > 0) do_pop();
        do_sync();
        for (int i = 1; i <= 3; i++) send_word(16'(i), "sync_pre");
        do_sync();
        send_word(16'h0004, "sync_post");
        send_word(16'h0005, "sync_post2");
        send_coincident(16'h0006, 0, "sync_coinc");
        send_word(16'h0007, "after_coinc");
        while (mfifo.size() > 0) do_pop();

        // Frame sync re-asserted after 8 bits.
        send_bits(16'h5555, 15, 8, 1'b1);
        repeat (4) @(negedge clk);
        exp_ferr++;
        send_word(16'h0ABC, "frame");
        do_pop();

        // Fill, overflow, clear priorities, full push+pop, then reset mid-word.
        for (int i = 0; i < 17; i++) send_word(16'h0100 + 16'(i), "fill");
        send_coincident(16'h0200, 1, "clr_vs_drop");
        do_clr();
        check("ovf_cleared", {31'd0, bus.overflow}, {31'd0, m_ovf});
        send_coincident(16'h0300, 2, "full_push_pop");
        for (int i = 0; i < 4; i++) do_pop();
        send_bits(16'h1234, 15, 11, 1'b1);
        @(negedge clk);
        rst_l = 1'b0;
        mfifo.delete();
        m_ch = 0;
        m_ovf = 1'b0;
        repeat (3) @(negedge clk);
        rst_l = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_mid_empty", {31'd0, bus.empty}, 32'd1);
        check("rst_mid_ovf", {31'd0, bus.overflow}, 32'd0);
        send_bits(16'h1234, 10, 0, 1'b0);
        settle_check("rest_ignored");
        send_word(16'h0042, "after_rst");
        do_pop();

        // Empty FIFO, push and pop request on the same cycle.
        send_coincident(16'h0055, 2, "empty_push_pop");
        do_pop();

        // Randomized traffic.
        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                do_sync();
            end else if (r <= 3) begin
                do_pop();
            end else if (r == 4) begin
                do_clr();
            end else begin
                w = 16'($urandom);
                w[15] = ($urandom_range(0, 3) == 0);
                send_word(w, "rand");
            end
        end
        while (mfifo.size() > 0) do_pop();
        do_pop();
        repeat (10) @(negedge clk);

        check("rd_pending", exp_rd_q.size(), 32'd0);
        check("ctrl_pending", exp_ctrl_q.size(), 32'd0);
        check("frame_err_count", seen_ferr, exp_ferr);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
